blink_rate_selector: RTL
========================

Name: blink_rate_selector

Overview:
- Upstream control stage for the LED blinker. It turns a raw push-button into a blink mode: OFF, SLOW, FAST or ON.
- In SLOW and FAST it generates a one-cycle `tick` enable. The blinker toggles its LED on each tick instead of free-running on a fixed counter.
- In ON it asserts `led_force` so the LED stays lit.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a button level change.
- SLOW_DIV, 65536: tick period in cycles in SLOW mode; must be ≥2.
- FAST_DIV, 16384: tick period in cycles in FAST mode; must be ≥2.
- LONG_PRESS_CYCLES, 2000000: debounced-high hold time that forces OFF; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- btn_raw  in  1  asynchronous push-button input, active-high
- btn_pulse  out  1  one-cycle pulse per accepted press (debounced rising edge)
- mode  out  2  current mode: 0=OFF, 1=SLOW, 2=FAST, 3=ON
- tick  out  1  one-cycle enable pulse for the downstream blinker
- led_force  out  1  1 only in ON mode

Behaviour:

Reset (rst high at a clk edge):
- mode=OFF; tick=0; btn_pulse=0; led_force=0.
- Synchronizer flops, debounced level, debounce counter, prescaler and long-press counter all go to 0.

Synchronizer:
- btn_raw passes through a 2-flop synchronizer to give s2.

Debounce:
- If s2 equals the debounced level, the counter is cleared.
- Otherwise the counter increments. When s2 has differed for DEBOUNCE_CYCLES consecutive cycles, the debounced level takes s2 and the counter clears.
- Any bounce back restarts the count.

Edge detect:
- btn_pulse is registered and is high for exactly one cycle after the debounced level goes 0→1.
- A falling edge produces no pulse.

Mode state machine:
- Advances on every clk edge that samples btn_pulse=1: OFF→SLOW→FAST→ON→OFF (wraps).
- mode changes one cycle after btn_pulse is seen.

Prescaler (width $clog2 of the larger divisor):
- In SLOW/FAST it counts 0..DIV-1 and wraps to 0.
- On the wrap edge, tick is registered to 1 for exactly one cycle.
- On any mode change the prescaler clears to 0 in the same edge.
- The first tick is high in the cycle after the DIV-th edge following the mode change. After that, one tick every DIV cycles.
- No tick is ever produced from a count accumulated in a previous mode.
- In OFF and ON the prescaler is held at 0 and tick stays 0.

Outputs:
- led_force = (mode==ON), registered together with mode.

Boundary conditions:
- A button held high through reset produces exactly one btn_pulse, DEBOUNCE_CYCLES+3 cycles after rst falls.
- Reset mid-count aborts the count and no tick is emitted.
- btn_pulse and a prescaler wrap in the same cycle: the mode change wins, the prescaler clears and tick is 0.

Optional Feature:
- Macro: BLINK_LONG_PRESS_EN.
- Defined:
  - A counter runs while the debounced level is 1.
  - On reaching LONG_PRESS_CYCLES, mode is forced to OFF once and the prescaler clears.
  - The counter saturates until release, so only one force per hold.
  - The short-press advance from the rising edge still occurs first.
- Undefined: no long-press counter exists; holding the button has no effect beyond the single press.

Decomposition:
- Package blink_pkg:
  - typedef enum logic[1:0] blink_mode_t {MODE_OFF, MODE_SLOW, MODE_FAST, MODE_ON}.
  - Default divisor and debounce constants.
- Sub-module btn_debouncer: synchronizer, debounce counter and rising-edge pulse. Parameter DEBOUNCE_CYCLES; ports clk, rst, btn_raw, btn_level, btn_pulse.
- Top level: mode FSM, prescaler, optional long-press logic.

Test Plan (DEBOUNCE_CYCLES=4, SLOW_DIV=8, FAST_DIV=4, LONG_PRESS_CYCLES=20):
1. Reset: rst=1 for 3 cycles with btn_raw=0 → mode=0, tick=0, led_force=0, btn_pulse=0 throughout.
2. Glitch: btn_raw high for 3 cycles, then low → no btn_pulse; mode stays 0.
3. Clean press: btn_raw high for 12 cycles → exactly one btn_pulse; mode=1; ticks 1 cycle wide, spaced exactly 8 cycles apart; first tick 8 cycles after the mode change.
4. Second press → mode=2; tick period 4; no stray tick at the transition. Third press → mode=3, led_force=1, tick=0. Fourth press → mode=0, led_force=0.
5. Reset mid-SLOW with prescaler at 5 → next cycle mode=0, tick=0. With btn_raw held high through reset → one btn_pulse 7 cycles after rst falls.
6. With BLINK_LONG_PRESS_EN, from mode=2, hold btn_raw high for 40 cycles → mode 3, then mode 0 once the hold reaches 20 debounced cycles; no further change until release. Without the macro → mode stays 3.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared mode encoding and default timing constants for the LED blink-rate selector.
package blink_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_SLOW = 2'd1,
    MODE_FAST = 2'd2,
    MODE_ON   = 2'd3
  } blink_mode_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES   = 50000;
  localparam int DEFAULT_SLOW_DIV          = 65536;
  localparam int DEFAULT_FAST_DIV          = 16384;
  localparam int DEFAULT_LONG_PRESS_CYCLES = 2000000;

  // Button presses cycle OFF -> SLOW -> FAST -> ON -> OFF; the 2-bit add wraps naturally.
  function automatic blink_mode_t nextMode(input blink_mode_t current);
    return blink_mode_t'(current + 2'd1);
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Two-flop synchronizer, counter-based debouncer and registered rising-edge pulse
// for a raw push-button input.
module btn_debouncer import blink_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          levelDly_q;
  logic          pulse_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The level is accepted only after the synchronized input has disagreed with it
  // on DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      level_q    <= 1'b0;
      levelDly_q <= 1'b0;
      pulse_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      levelDly_q <= level_q;
      pulse_q    <= level_q & ~levelDly_q;
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule

// File: rtl/blink_rate_selector.sv
// Push-button driven blink-mode selector with tick prescaler for the LED blinker.
// Optional long-press force-to-OFF is enabled by defining BLINK_LONG_PRESS_EN.
module blink_rate_selector import blink_pkg::*; #(
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SLOW_DIV          = DEFAULT_SLOW_DIV,
  parameter int FAST_DIV          = DEFAULT_FAST_DIV,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       btn_pulse,
  output logic [1:0] mode,
  output logic       tick,
  output logic       led_force
);

  localparam int            MAX_DIV   = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int            PW        = $clog2(MAX_DIV);
  localparam logic [PW-1:0] SLOW_LAST = PW'(SLOW_DIV - 1);
  localparam logic [PW-1:0] FAST_LAST = PW'(FAST_DIV - 1);

  logic          btnLevel;
  logic          btnPulse;
  blink_mode_t   mode_q;
  blink_mode_t   mode_d;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic [PW-1:0] divLast;
  logic          tick_q;
  logic          tick_d;
  logic          ledForce_q;
  logic          running;

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_level(btnLevel),
    .btn_pulse(btnPulse)
  );

`ifdef BLINK_LONG_PRESS_EN
  localparam int            LW      = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [LW-1:0] LP_MAX  = LW'(LONG_PRESS_CYCLES);
  localparam logic [LW-1:0] LP_LAST = LW'(LONG_PRESS_CYCLES - 1);

  logic [LW-1:0] lpCnt_q;
  logic [LW-1:0] lpCnt_d;
  logic          lpForce;

  // Saturating hold counter: the force fires on the single edge that reaches the limit.
  always_comb begin
    lpCnt_d = '0;
    lpForce = 1'b0;
    if (btnLevel) begin
      lpCnt_d = (lpCnt_q == LP_MAX) ? lpCnt_q : lpCnt_q + 1'b1;
      lpForce = (lpCnt_q == LP_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lpCnt_q <= '0;
    end else begin
      lpCnt_q <= lpCnt_d;
    end
  end
`else
  localparam int unusedLongPress = LONG_PRESS_CYCLES;
  logic          unusedBtnLevel;
  logic          lpForce;

  assign unusedBtnLevel = btnLevel;
  assign lpForce        = 1'b0;
`endif

  assign running = (mode_q == MODE_SLOW) || (mode_q == MODE_FAST);
  assign divLast = (mode_q == MODE_SLOW) ? SLOW_LAST : FAST_LAST;

  // A mode change (press or long-press force) always clears the prescaler and
  // suppresses the tick, so no tick ever comes from a previous mode's count.
  always_comb begin
    mode_d  = mode_q;
    presc_d = '0;
    tick_d  = 1'b0;
    if (btnPulse) begin
      mode_d = nextMode(mode_q);
    end else if (running) begin
      if (presc_q == divLast) begin
        tick_d = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    if (lpForce) begin
      mode_d  = MODE_OFF;
      presc_d = '0;
      tick_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_OFF;
      presc_q    <= '0;
      tick_q     <= 1'b0;
      ledForce_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      ledForce_q <= (mode_d == MODE_ON);
    end
  end

  assign btn_pulse = btnPulse;
  assign mode      = mode_q;
  assign tick      = tick_q;
  assign led_force = ledForce_q;

endmodule
